// File: rtl/dm_ctrl_if.sv
// Request/response bus between a load-store unit (master) and the dm_ctrl data memory (slave).
interface dm_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [2:0]  ldtype;
   logic [31:0] pc;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, be, wd, ldtype, pc,
      input  ready, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, be, wd, ldtype, pc,
      output ready, rvalid, rdata, err
   );
endinterface

// File: rtl/dm_ctrl.sv
// Data memory controller: zeroes the array after reset, then serves loads/stores at one per cycle.
// Define DM_TRACE_EN to print one line per committed store.
module dm_ctrl #(
   parameter int unsigned DEPTH = 3072,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input logic      clk,
   input logic      reset,
   dm_ctrl_if.slave bus
);
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_BU = 3'd1;
   localparam logic [2:0] LD_B  = 3'd2;
   localparam logic [2:0] LD_HU = 3'd3;
   localparam logic [2:0] LD_H  = 3'd4;

   typedef enum logic {CLEAR, RUN} state_e;

   state_e        state;
   logic [AW-1:0] cnt;
   logic          ready_q;
   logic          rv_q;
   logic          err_q;
   logic [1:0]    lane_q;
   logic [2:0]    ld_q;
   logic [31:0]   rd_word;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          misaligned;
   logic          accept;
   logic          bad;
   logic          store_ok;
   logic          load_ok;

   assign off      = bus.addr - BASE;
   assign idx      = off[AW+1:2];
   assign in_range = off < SPAN;
   assign accept   = bus.req & ready_q;
   assign bad      = ~in_range | misaligned;
   assign store_ok = accept & bus.we & ~bad;
   assign load_ok  = accept & ~bus.we & ~bad;

   always_comb begin
      // NOTE: default assignment first so every path drives the signal and no latch is inferred.
      misaligned = 1'b0;
      if (bus.we) begin
         misaligned = (bus.be == 4'b0000);
      end else begin
         case (bus.ldtype)
            LD_W:         misaligned = (bus.addr[1:0] != 2'b00);
            LD_HU, LD_H:  misaligned = bus.addr[0];
            LD_BU, LD_B:  misaligned = 1'b0;
            default:      misaligned = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         cnt     <= '0;
         ready_q <= 1'b0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
         lane_q  <= 2'b00;
         ld_q    <= LD_W;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the pre-edge values.
         case (state)
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(DEPTH - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               rv_q   <= accept & (bad | ~bus.we);
               err_q  <= accept & bad;
               lane_q <= bus.addr[1:0];
               ld_q   <= bus.ldtype;
            end
         endcase
      end
   end

   // NOTE: the array itself has no reset; the CLEAR sweep zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (store_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wd[8*i +: 8];
         end
      end
      if (load_ok) rd_word <= mem[idx];
   end

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   assign sel_b = rd_word[{lane_q, 3'b000} +: 8];
   assign sel_h = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      bus.rdata = '0;
      if (rv_q && !err_q) begin
         case (ld_q)
            LD_W:    bus.rdata = rd_word;
            LD_BU:   bus.rdata = {24'h0, sel_b};
            LD_B:    bus.rdata = {{24{sel_b[7]}}, sel_b};
            LD_HU:   bus.rdata = {16'h0, sel_h};
            LD_H:    bus.rdata = {{16{sel_h[15]}}, sel_h};
            default: bus.rdata = '0;
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.rvalid = rv_q;
   assign bus.err    = err_q;

`ifdef DM_TRACE_EN
   logic [31:0] merged;

   always_comb begin
      merged = mem[idx];
      for (int i = 0; i < 4; i++) begin
         if (bus.be[i]) merged[8*i +: 8] = bus.wd[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (store_ok)
         $display("%0t@0x%08h: *0x%08h <= 0x%08h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^bus.pc;
`endif
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, the data memory size in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, the byte address of word 0 (word-aligned).
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-005 SHALL have port req, input, 1 bit; access request, sampled when ready=1.
REQ-006 SHALL have port we, input, 1 bit; 1 = store, 0 = load.
REQ-007 SHALL have port addr, input, 32 bits; byte address.
REQ-008 SHALL have port be, input, 4 bits; store byte enables, bit i enables wd[8i+7:8i].
REQ-009 SHALL have port wd, input, 32 bits; store data, already lane-aligned.
REQ-010 SHALL have port ldtype, input, 3 bits; load type: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh (5-7 illegal).
REQ-011 SHALL have port pc, input, 32 bits; PC of the issuing instruction (trace only).
REQ-012 SHALL have port ready, output, 1 bit; the block accepts a request this cycle.
REQ-013 SHALL have port rvalid, output, 1 bit; response valid.
REQ-014 SHALL have port rdata, output, 32 bits; extended load data.
REQ-015 SHALL have port err, output, 1 bit; the accepted access was rejected.

Function
REQ-016 SHALL implement a two-state FSM (CLEAR, RUN) plus a 1-deep response register.
REQ-017 SHALL, in CLEAR, write zero to word cnt each cycle (cnt 0..DEPTH-1, width clog2(DEPTH)), hold ready=0, and ignore req.
REQ-018 SHALL move from CLEAR to RUN on the cycle after the write of word DEPTH-1; ready=1 in every RUN cycle.
REQ-019 SHALL treat an access as accepted when req=1 and ready=1 on a rising clk edge.
REQ-020 SHALL treat an access as in range when (addr-BASE) < 4*DEPTH, unsigned 32-bit; word index = (addr-BASE)>>2.
REQ-021 SHALL treat an access as misaligned when: lw with addr[1:0]!=0; lh/lhu with addr[0]=1; illegal ldtype on a load; store with be=0.
REQ-022 SHALL, for an accepted legal store, update only the enabled bytes at that edge and produce no response (rvalid stays 0).
REQ-023 SHALL, for an accepted legal load, assert rvalid=1 and err=0 for exactly one cycle, in the cycle after acceptance, with rdata extended per ldtype using the byte/half selected by the registered addr[1:0].
REQ-024 SHALL, for an accepted out-of-range or misaligned access, leave memory unchanged and assert rvalid=1, err=1, rdata=0 for one cycle after acceptance (stores included).
REQ-025 SHALL accept back-to-back requests every cycle (throughput 1); the response for cycle N appears in cycle N+1.
REQ-026 SHALL return the newly written data for a load to the same word accepted the cycle after a store.
REQ-027 SHALL drive rdata=0 and err=0 whenever rvalid=0.

Reset
REQ-028 SHALL, while reset=1, immediately force state=CLEAR, cnt=0, ready=0, rvalid=0, err=0, rdata=0.
REQ-029 SHALL, on reset asserted mid-sweep or mid-access, abandon the in-flight response and restart the sweep from word 0 after reset deasserts.

Configuration
REQ-030 SHALL, when macro DM_TRACE_EN is defined, print one line per committed legal store: "<time>@<pc>: *<word byte address> <= <merged 32-bit word>" (hex), merged = old word with enabled bytes replaced.
REQ-031 SHALL, without DM_TRACE_EN, contain no trace logic and have identical port behaviour.

Verification
REQ-032 SHALL verify reset then wait: ready=0 for exactly 3072 cycles after reset deasserts, then 1; lw 0x0000_0BFC -> rdata=0.
REQ-033 SHALL verify: sw 0x0000_0010 wd=0x8765_43A1 be=1111, then lb 0x11 -> rdata=0x0000_0043; lb 0x10 -> 0xFFFF_FFA1; lhu 0x12 -> 0x0000_8765; lh 0x12 -> 0xFFFF_8765.
REQ-034 SHALL verify: store be=0010 wd=0x0000_5500 to 0x20 over 0xFFFF_FFFF, next-cycle lw 0x20 -> 0xFFFF_55FF.
REQ-035 SHALL verify: lw 0x3000 (out of range) -> err=1, rvalid=1, rdata=0; sw 0x3000 -> err=1, no word modified; lh 0x13 -> err=1.
REQ-036 SHALL verify: reset asserted during the RUN cycle after a lw accept -> no rvalid, and the sweep restarts with ready=0.
REQ-037 SHALL verify: with DM_TRACE_EN, sw pc=0x3000 to 0x24 be=1100 wd=0x1234_0000 over 0 -> trace line shows 0x00000024 <= 0x12340000.
